serial_add_ctrl: RTL and testbench

//   Bit-serial adder sequencer. Accepts two WIDTH-bit operands on a start pulse and

---
 rtl/serial_add_pkg.sv | 28 ++
 rtl/serial_add_ctrl_if.sv | 40 ++++
 rtl/ha_cell.sv | 18 +
 rtl/serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_serial_add_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module : serial_add_pkg
// Brief  : State encoding and counter-width helper for the bit-serial adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..n-1; never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
// ============================================================================
// Module : serial_add_ctrl_if
// Brief  : Request/result bundle for serial_add_ctrl (sub only with SERIAL_ADD_SUB_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  start, a, b,
        output busy, done, sum, cout
    );

endinterface

`default_nettype wire

// File: rtl/ha_cell.sv
// ============================================================================
// Module : ha_cell
// Brief  : One-bit half adder cell.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ha_cell (
    input  wire logic i_x,
    input  wire logic i_y,
    output logic      o_s,
    output logic      o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module : serial_add_ctrl
// Brief  : LSB-first bit-serial adder sequencer, one bit per clock.
//          SERIAL_ADD_SUB_EN adds the sub port for two's-complement subtract.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int            CW   = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic               carry_q, carry_d;
    logic [WIDTH-2:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               w_s0, w_c0, w_s1, w_c1;
    logic               w_fa_s, w_fa_c;
    logic [WIDTH-1:0]   w_res_cat;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_carry_load;

    ha_cell u_ha0 (.i_x(a_sh_q[0]), .i_y(b_sh_q[0]), .o_s(w_s0), .o_c(w_c0));
    ha_cell u_ha1 (.i_x(w_s0),      .i_y(carry_q),   .o_s(w_s1), .o_c(w_c1));

    assign w_fa_s = w_s1;
    assign w_fa_c = w_c0 | w_c1;

    // The WIDTH-1 bit result reg plus the live slice bit form the full sum.
    assign w_res_cat = {w_fa_s, res_q};

`ifdef SERIAL_ADD_SUB_EN
    assign w_b_load     = bus.sub ? ~bus.b : bus.b;
    assign w_carry_load = bus.sub;
`else
    assign w_b_load     = bus.b;
    assign w_carry_load = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = w_b_load;
                    carry_d = w_carry_load;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d   = w_res_cat[WIDTH-1:1];
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = w_fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = w_res_cat;
                    cout_d  = w_fa_c;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module : tb_serial_add_ctrl
// Brief  : Scoreboard bench for serial_add_ctrl at WIDTH=8.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();
    serial_add_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int checks   = 0;
    int failures = 0;
    logic [WIDTH:0] exp_q [$];

    // Drive operands and push the reference result {cout, sum}.
    task automatic drive_op(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                            input logic sub_v);
        logic [WIDTH:0] e;
        bus.a = a_v;
        bus.b = b_v;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = sub_v;
`endif
        if (sub_v) e = {1'b0, a_v} + {1'b0, ~b_v} + (WIDTH+1)'(1);
        else       e = {1'b0, a_v} + {1'b0, b_v};
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge where done is high.
    task automatic wait_done(output int nbusy, output bit ok);
        nbusy = 0;
        ok    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
            failures++;
            $display("FAIL reset_result sum=%h cout=%b required 00 0", bus.sum, bus.cout);
        end
    endtask

    task automatic test_add();
        int nb;
        bit ok;
        logic [WIDTH:0] e;
        drive_op(8'h3C, 8'h05, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 8'hAA;
        wait_done(nb, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL add_timeout done=0 required 1");
        end
        checks++;
        if (nb !== 8) begin
            failures++;
            $display("FAIL add_busy_cycles got=%0d required 8", nb);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL add_busy_in_done busy=%b required 0", bus.busy);
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.cout, bus.sum} !== e) begin
            failures++;
            $display("FAIL add_result got=%h required=%h", {bus.cout, bus.sum}, e);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL add_after_done busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.sum !== 8'h41 || bus.cout !== 1'b0) begin
            failures++;
            $display("FAIL add_hold sum=%h cout=%b required 41 0", bus.sum, bus.cout);
        end
    endtask

    task automatic test_carry();
        logic [WIDTH-1:0] ta [2];
        logic [WIDTH-1:0] tb [2];
        int nb;
        bit ok;
        logic [WIDTH:0] e;
        ta[0] = 8'hFF; tb[0] = 8'h01;
        ta[1] = 8'h80; tb[1] = 8'h80;
        for (int k = 0; k < 2; k++) begin
            drive_op(ta[k], tb[k], 1'b0);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            wait_done(nb, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL carry_timeout case=%0d done=0 required 1", k);
                void'(exp_q.pop_front());
            end else begin
                e = exp_q.pop_front();
                if ({bus.cout, bus.sum} !== e || e !== 9'h100) begin
                    failures++;
                    $display("FAIL carry_result case=%0d got=%h required=100", k, {bus.cout, bus.sum});
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        bit ok;
        logic [WIDTH:0] e;
        drive_op(8'h01, 8'h02, 1'b0);
        bus.start = 1'b1;
        repeat (4) @(negedge clk);
        bus.a = 8'h10;
        wait_done(nb, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_first_timeout done=0 required 1");
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.cout, bus.sum} !== e) begin
            failures++;
            $display("FAIL b2b_first_result got=%h required=%h", {bus.cout, bus.sum}, e);
        end
        drive_op(8'h10, 8'h02, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart busy=%b required 1", bus.busy);
        end
        bus.start = 1'b0;
        wait_done(nb, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {bus.cout, bus.sum} !== e) begin
            failures++;
            $display("FAIL b2b_second_result ok=%b got=%h required=%h", ok, {bus.cout, bus.sum}, e);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int nb;
        bit ok;
        int seen_done;
        logic [WIDTH:0] e;
        bus.a = 8'hAA;
        bus.b = 8'h11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_ctrl busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
            failures++;
            $display("FAIL abort_result sum=%h cout=%b required 00 0", bus.sum, bus.cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL abort_no_done active_cycles=%0d required 0", seen_done);
        end
        drive_op(8'h7F, 8'h01, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(nb, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {bus.cout, bus.sum} !== e) begin
            failures++;
            $display("FAIL abort_recover ok=%b got=%h required=%h", ok, {bus.cout, bus.sum}, e);
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        logic [WIDTH-1:0] ta [2];
        logic [WIDTH-1:0] tb [2];
        logic [WIDTH:0]   tr [2];
        int nb;
        bit ok;
        logic [WIDTH:0] e;
        ta[0] = 8'h05; tb[0] = 8'h07; tr[0] = 9'h0FE;
        ta[1] = 8'h07; tb[1] = 8'h05; tr[1] = 9'h102;
        for (int k = 0; k < 2; k++) begin
            drive_op(ta[k], tb[k], 1'b1);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            bus.sub = 1'b0;
            wait_done(nb, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || {bus.cout, bus.sum} !== e || e !== tr[k]) begin
                failures++;
                $display("FAIL sub_result case=%0d got=%h required=%h", k, {bus.cout, bus.sum}, tr[k]);
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_back_to_back();
        test_abort();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
